cmp_stream_packer: RTL and testbench

- Sits directly downstream of the compressor.
- Takes one variable-length compressed record per cycle: a 3-bit pattern select plus payload, already LSB-aligned, with its bit count.
- Concatenates the records LSB-first into a continuous bitstream and emits fixed 512-bit words to the memory-write side, using a valid/ready handshake.
- Supports an explicit flush that drains the buffer and emits a zero-padded tail word.

---
 rtl/cmp_stream_packer.sv | 81 ++++++++
 tb/tb_cmp_stream_packer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cmp_stream_packer.sv
// cmp_stream_packer: packs variable-length compressed records LSB-first into 512-bit words
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   data_i, size_i      record (valid bits [size_i-1:0]) and its length in bits
//   en_i                record valid (upstream cannot stall)
//   flush_i             request to drain all buffered bits as a zero-padded tail word
//   ready_o             a record can be accepted this cycle
//   word_o, word_bits_o packed output word (bit 0 oldest) and its valid bit count
//   word_valid_o        word_o valid; held stable until word_ready_i
//   word_ready_i        downstream accepts word_o
//   flush_done_o        one-cycle pulse when a flush completes
//   ovf_o               sticky: a record was dropped
module cmp_stream_packer #(
  parameter int IN_W   = 259,
  parameter int SIZE_W = 9,
  parameter int OUT_W  = 512,
  parameter int ACC_W  = 1024,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   data_i,
  input  logic [SIZE_W-1:0] size_i,
  input  logic              en_i,
  input  logic              flush_i,
  output logic              ready_o,
  output logic [OUT_W-1:0]  word_o,
  output logic [9:0]        word_bits_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              flush_done_o,
  output logic              ovf_o
);
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d, acc_p;
  logic [CNT_W-1:0]   fill_q, fill_d, fill_p;
  logic [SIZE_W-1:0]  sz;
  logic [IN_W-1:0]    rec;
  logic               free, pop, tail, push;
  assign ready_o      = !rst && state_q == RUN && fill_q <= CNT_W'(ACC_W - IN_W);
  assign flush_done_o = state_q == DONE;
  always_comb begin
    sz      = size_i > SIZE_W'(IN_W) ? SIZE_W'(IN_W) : size_i;
    rec     = data_i & ~({IN_W{1'b1}} << sz);
    free    = !word_valid_o || word_ready_i;
    pop     = free && fill_q >= CNT_W'(OUT_W);
    // bits above fill are always zero, so the low slice is already zero-padded
    tail    = state_q == DRAIN && free && !pop && fill_q != '0;
    push    = en_i && ready_o && sz != '0;
    acc_p   = pop ? acc_q >> OUT_W : acc_q;
    fill_p  = pop ? fill_q - CNT_W'(OUT_W) : fill_q;
    acc_d   = (tail ? '0 : acc_p) | (push ? ACC_W'(rec) << fill_p : '0);
    fill_d  = tail ? '0 : fill_p + (push ? CNT_W'(sz) : '0);
    state_d = state_q == RUN   ? (flush_i ? DRAIN : RUN) :
              state_q == DRAIN ? (fill_q == '0 && free ? DONE : DRAIN) : RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      word_o       <= '0;
      word_bits_o  <= '0;
      word_valid_o <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      if (pop || tail) begin
        word_o       <= acc_q[OUT_W-1:0];
        word_bits_o  <= pop ? 10'(OUT_W) : 10'(fill_q);
        word_valid_o <= 1'b1;
      end else if (free) begin
        word_valid_o <= 1'b0;
      end
      if (en_i && !ready_o && sz != '0) ovf_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cmp_stream_packer.sv
// tb_cmp_stream_packer: table-driven directed checks of the stream packer
module tb_cmp_stream_packer;
  localparam int IN_W = 259, OUT_W = 512;
  logic             clk = 0, rst, en_i, flush_i, word_ready_i;
  logic [IN_W-1:0]  data_i;
  logic [8:0]       size_i;
  logic             ready_o, word_valid_o, flush_done_o, ovf_o;
  logic [OUT_W-1:0] word_o;
  logic [9:0]       word_bits_o;
  int checks = 0, errors = 0;

  cmp_stream_packer dut (
    .clk(clk), .rst(rst), .data_i(data_i), .size_i(size_i), .en_i(en_i),
    .flush_i(flush_i), .ready_o(ready_o), .word_o(word_o), .word_bits_o(word_bits_o),
    .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .flush_done_o(flush_done_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst, en, fl, wr;
    int   sz;
    logic v;
    int   bits, ones;
    logic rdy, dn, ovf;
  } vec_t;
  vec_t vt[$];

  function automatic logic [OUT_W-1:0] ones(int n);
    logic [OUT_W-1:0] m;
    m = '0;
    for (int i = 0; i < n && i < OUT_W; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic row(input logic r, e, f, w, input int sz,
                     input logic v, input int bits, input int on,
                     input logic rdy, dn, ov);
    vec_t x;
    x.rst = r; x.en = e; x.fl = f; x.wr = w; x.sz = sz;
    x.v = v; x.bits = bits; x.ones = on; x.rdy = rdy; x.dn = dn; x.ovf = ov;
    vt.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [OUT_W-1:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //  rst en fl wr  sz    v  bits ones rdy dn ovf
    row(1, 0, 0, 1,   0,   0,   0,   0, 0, 0, 0);  // reset
    row(0, 1, 0, 1, 259,   0,   0,   0, 1, 0, 0);  // fill 259
    row(0, 1, 0, 1, 259,   0,   0,   0, 1, 0, 0);  // fill 518
    row(0, 0, 0, 1,   0,   1, 512, 512, 1, 0, 0);  // pop, fill 6
    row(0, 0, 1, 1,   0,   0, 512, 512, 0, 0, 0);  // -> DRAIN
    row(0, 0, 0, 1,   0,   1,   6,   6, 0, 0, 0);  // tail of 6
    row(0, 0, 0, 1,   0,   0,   6,   6, 0, 1, 0);  // DONE
    row(0, 0, 0, 1,   0,   0,   6,   6, 1, 0, 0);  // RUN
    row(0, 1, 0, 1,   3,   0,   6,   6, 1, 0, 0);  // 3-bit record
    row(0, 0, 1, 1,   0,   0,   6,   6, 0, 0, 0);
    row(0, 0, 0, 1,   0,   1,   3,   3, 0, 0, 0);  // tail 0x7
    row(0, 0, 0, 1,   0,   0,   3,   3, 0, 1, 0);
    row(0, 0, 0, 1,   0,   0,   3,   3, 1, 0, 0);
    row(0, 1, 0, 1,   0,   0,   3,   3, 1, 0, 0);  // size 0: no-op
    row(0, 1, 0, 1, 300,   0,   3,   3, 1, 0, 0);  // clamped to 259
    row(0, 0, 1, 1,   0,   0,   3,   3, 0, 0, 0);
    row(0, 0, 0, 1,   0,   1, 259, 259, 0, 0, 0);
    row(0, 0, 0, 1,   0,   0, 259, 259, 0, 1, 0);
    row(0, 0, 0, 1,   0,   0, 259, 259, 1, 0, 0);
    row(0, 1, 1, 1, 100,   0, 259, 259, 0, 0, 0);  // push + flush same cycle
    row(0, 0, 0, 1,   0,   1, 100, 100, 0, 0, 0);
    row(0, 0, 0, 1,   0,   0, 100, 100, 0, 1, 0);
    row(0, 0, 0, 1,   0,   0, 100, 100, 1, 0, 0);
    row(0, 1, 0, 1,   5,   0, 100, 100, 1, 0, 0);  // accepting again
    row(0, 0, 1, 1,   0,   0, 100, 100, 0, 0, 0);
    row(0, 0, 0, 1,   0,   1,   5,   5, 0, 0, 0);
    row(0, 0, 0, 1,   0,   0,   5,   5, 0, 1, 0);
    row(0, 0, 0, 1,   0,   0,   5,   5, 1, 0, 0);
    row(0, 0, 1, 1,   0,   0,   5,   5, 0, 0, 0);  // flush on empty
    row(0, 0, 0, 1,   0,   0,   5,   5, 0, 1, 0);  // DONE, no word
    row(0, 0, 0, 1,   0,   0,   5,   5, 1, 0, 0);
    row(0, 1, 0, 0, 259,   0,   5,   5, 1, 0, 0);  // backpressure: 259
    row(0, 1, 0, 0, 259,   0,   5,   5, 1, 0, 0);  // 518
    row(0, 1, 0, 0, 259,   1, 512, 512, 1, 0, 0);  // pop+push: 265
    row(0, 1, 0, 0, 259,   1, 512, 512, 1, 0, 0);  // 524
    row(0, 1, 0, 0, 259,   1, 512, 512, 0, 0, 0);  // 783, not ready
    row(0, 1, 0, 0, 259,   1, 512, 512, 0, 0, 1);  // dropped
    row(0, 0, 0, 0,   0,   1, 512, 512, 0, 0, 1);  // held
    row(0, 0, 0, 1,   0,   1, 512, 512, 1, 0, 1);  // pop, 271
    row(0, 0, 0, 1,   0,   0, 512, 512, 1, 0, 1);
    row(1, 0, 0, 1,   0,   0,   0,   0, 0, 0, 0);  // reset clears ovf
    row(0, 1, 0, 0, 259,   0,   0,   0, 1, 0, 0);  // build fill 300
    row(0, 1, 0, 0, 259,   0,   0,   0, 1, 0, 0);
    row(0, 1, 0, 0, 259,   1, 512, 512, 1, 0, 0);
    row(0, 1, 0, 0,  35,   1, 512, 512, 1, 0, 0);  // fill 300
    row(0, 0, 1, 0,   0,   1, 512, 512, 0, 0, 0);  // DRAIN, stalled
    row(0, 0, 0, 0,   0,   1, 512, 512, 0, 0, 0);
    row(1, 0, 0, 0,   0,   0,   0,   0, 0, 0, 0);  // reset in DRAIN
    row(0, 0, 0, 1,   0,   0,   0,   0, 1, 0, 0);
    row(0, 0, 0, 1,   0,   0,   0,   0, 1, 0, 0);
    row(0, 0, 1, 1,   0,   0,   0,   0, 0, 0, 0);  // buffer proven empty
    row(0, 0, 0, 1,   0,   0,   0,   0, 0, 1, 0);
    row(0, 0, 0, 1,   0,   0,   0,   0, 1, 0, 0);

    data_i = '1;
    for (int i = 0; i < vt.size(); i++) begin
      rst = vt[i].rst; en_i = vt[i].en; flush_i = vt[i].fl;
      word_ready_i = vt[i].wr; size_i = 9'(vt[i].sz);
      @(posedge clk); #1;
      chk("valid", i, OUT_W'(word_valid_o), OUT_W'(vt[i].v));
      chk("bits",  i, OUT_W'(word_bits_o),  OUT_W'(vt[i].bits));
      chk("word",  i, word_o,               ones(vt[i].ones));
      chk("ready", i, OUT_W'(ready_o),      OUT_W'(vt[i].rdy));
      chk("done",  i, OUT_W'(flush_done_o), OUT_W'(vt[i].dn));
      chk("ovf",   i, OUT_W'(ovf_o),        OUT_W'(vt[i].ovf));
    end

    // offset/masking: 8 bits 0xA5 then 4 bits 0x3, junk above each size
    word_ready_i = 1; flush_i = 0; en_i = 1;
    data_i = {{(IN_W-8){1'b1}}, 8'hA5}; size_i = 8;
    @(posedge clk); #1;
    data_i = {{(IN_W-8){1'b1}}, 8'hF3}; size_i = 4;
    @(posedge clk); #1;
    en_i = 0; flush_i = 1;
    @(posedge clk); #1;
    flush_i = 0;
    begin
      int n = 0;
      while (!word_valid_o && n < 20) begin @(posedge clk); #1; n++; end
      chk("seq_word_seen", 0, OUT_W'(word_valid_o), OUT_W'(1));
      chk("seq_word", 0, word_o, OUT_W'(12'h3A5));
      chk("seq_bits", 0, OUT_W'(word_bits_o), OUT_W'(12));
      n = 0;
      while (!flush_done_o && n < 20) begin @(posedge clk); #1; n++; end
      chk("seq_done", 0, OUT_W'(flush_done_o), OUT_W'(1));
      @(posedge clk); #1;
      chk("seq_done_pulse", 0, OUT_W'(flush_done_o), OUT_W'(0));
      chk("seq_ready", 0, OUT_W'(ready_o), OUT_W'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
